mem_bus_loader: RTL
===================

# mem_bus_loader

Bus initiator on the native PicoRV32 memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata). It takes a little-endian byte stream, packs it into 32-bit words, writes them into a memory responder, and reads the whole image back to check it. It holds the CPU in reset until the image is verified. It sits between a byte source (UART/JTAG bridge) and the on-chip RAM responder, arbitrated ahead of the CPU during boot.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- NUM_WORDS, 1024: words per image, 1..1024.
- TIMEOUT, 255: max wait cycles for mem_ready per transaction, 1..65535.

- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a load.
- byte_valid  in  1  byte stream valid.
- byte_data  in  8  byte stream data.
- byte_ready  out  1  byte accepted when byte_valid && byte_ready.
- mem_valid  out  1  transaction request.
- mem_instr  out  1  tied 0.
- mem_addr  out  32  word-aligned byte address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'b1111 for a write, 4'b0000 for a read.
- mem_ready  in  1  responder completion.
- mem_rdata  in  32  read data; valid in the cycle mem_ready=1.
- busy  out  1  high in every state except IDLE, DONE and ERROR.
- done  out  1  image written and verified.
- error  out  1  timeout or verify mismatch; sticky.
- cpu_resetn  out  1  CPU reset release; high only in DONE.
- checksum  out  32  sum mod 2^32 of the words written.

## Operation
- States:
  - IDLE: start -> COLLECT. Clears word index, byte count, checksum, done and error.
  - COLLECT: byte_ready=1. Each accepted byte fills lane [8*k+7:8*k], k=0..3. The 4th byte moves to WRITE; the word is added to checksum.
  - WRITE: mem_valid=1, wstrb=1111, addr=BASE_ADDR+4*index. When mem_ready is sampled high, index increments. If index reaches NUM_WORDS -> VERIFY_REQ with index=0 and readback sum=0; otherwise -> COLLECT.
  - VERIFY_REQ: mem_valid=1, wstrb=0000, same addressing. When mem_ready is sampled high, mem_rdata is added to the readback sum and index increments. After the last word, go to DONE if readback sum == checksum, else ERROR. Otherwise stay in VERIFY_REQ for the next address, after the mandatory idle cycle.
  - DONE: done=1, cpu_resetn=1. start -> COLLECT, clearing as IDLE does; cpu_resetn drops in the same cycle the state leaves DONE.
  - ERROR: error=1, cpu_resetn=0. start -> COLLECT, clearing as IDLE does.
- start is ignored while busy=1.
- Timeout: a counter clears when mem_valid rises and increments every cycle mem_valid=1 && mem_ready=0. Reaching TIMEOUT -> ERROR and mem_valid drops next cycle. A mem_ready arriving in the same cycle as the timeout wins: the transaction completes.
- mem_ready while mem_valid=0 is ignored.
- Checksum and index arithmetic is modulo 2^32. The index counter is wide enough for NUM_WORDS.

## Timing
- Reset values: mem_valid=0, mem_instr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, byte_ready=0, busy=0, done=0, error=0, cpu_resetn=0, checksum=0. State = IDLE.
- mem_addr, mem_wdata and mem_wstrb are registered and stable for the whole time mem_valid=1.
- A transaction completes on the edge where mem_valid && mem_ready. mem_valid is 0 for at least one cycle after every completion.
- Zero-wait responder: each transaction takes 2 cycles (valid, then idle). Combinational ready in the first valid cycle is legal.
- Registered responder (ready one cycle after valid): 3 cycles per transaction.
- Byte path: up to one byte per cycle. The 4th byte -> mem_valid high on the next cycle.
- Reset mid-transaction: mem_valid and all outputs drop asynchronously. No partial state survives.
- byte_valid during WRITE or VERIFY is not accepted (byte_ready=0). The source must hold the byte.

## Test plan
- NUM_WORDS=2, zero-wait RAM model, bytes 78 56 34 12 EF BE AD DE -> writes 0x12345678 @0x0 and 0xDEADBEEF @0x4, reads back both, done=1, cpu_resetn=1, checksum=0xF0E21567.
- Responder raises mem_ready 3 cycles after mem_valid, with byte_valid held continuously -> addr/wdata/wstrb stable across all valid cycles, byte_ready=0 while waiting, final done=1.
- TIMEOUT=4, responder never acks writes -> mem_valid high exactly 4 cycles, then error=1, busy=0, cpu_resetn=0. A following start restarts from COLLECT with error cleared.
- Responder corrupts read of word 1 (bit 0 flipped) -> error=1 after the last read, done=0.
- resetn pulsed low while a write is mid-wait -> mem_valid=0 immediately, state IDLE. A new start with a fresh stream loads correctly.
- start asserted during COLLECT and again in DONE -> first ignored; second drops cpu_resetn the same cycle and restarts the load.

Source files
------------

// File: rtl/mem_bus_loader_if.sv
// Native PicoRV32-style memory bus between the boot loader (master) and the RAM responder (slave).
interface mem_bus_loader_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_bus_loader.sv
// Boot image loader: packs a little-endian byte stream into words, writes them to RAM,
// reads the image back and compares sums, holding the CPU in reset until it verifies.
module mem_bus_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_start,
  input  logic             i_byte_valid,
  input  logic [7:0]       i_byte_data,
  output logic             o_byte_ready,
  mem_bus_loader_if.master bus,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic             o_cpu_resetn,
  output logic [31:0]      o_checksum
);

  localparam int unsigned   IW        = $clog2(NUM_WORDS + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_WORDS - 1);
  localparam logic [16:0]   TMO_LIMIT = 17'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_VERIFY  = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t        r_state,     w_state_nxt;
  logic [IW-1:0] r_index,     w_index_nxt;
  logic [1:0]    r_lane,      w_lane_nxt;
  logic [23:0]   r_word,      w_word_nxt;
  logic [31:0]   r_checksum,  w_checksum_nxt;
  logic [31:0]   r_rsum,      w_rsum_nxt;
  logic [15:0]   r_timer,     w_timer_nxt;
  logic          r_mem_valid, w_mem_valid_nxt;
  logic [31:0]   r_mem_addr,  w_mem_addr_nxt;
  logic [31:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic [3:0]    r_mem_wstrb, w_mem_wstrb_nxt;
  logic          r_byte_ready;
  logic          r_busy;
  logic          r_done;
  logic          r_error;
  logic          r_cpu_resetn;

  logic          w_fire;
  logic          w_last;
  logic          w_timeout;
  logic          w_byte_acc;
  logic [31:0]   w_full_word;
  logic [31:0]   w_idx32;
  logic [31:0]   w_addr;
  logic [31:0]   w_rsum_sum;

  assign w_fire      = r_mem_valid && bus.mem_ready;
  assign w_last      = (r_index == LAST_IDX);
  // A ready in the same cycle the wait budget runs out completes the transfer.
  assign w_timeout   = r_mem_valid && !bus.mem_ready && (({1'b0, r_timer} + 17'd1) == TMO_LIMIT);
  assign w_byte_acc  = r_byte_ready && i_byte_valid;
  assign w_full_word = {i_byte_data, r_word};
  assign w_idx32     = 32'(r_index);
  assign w_addr      = BASE_ADDR + (w_idx32 << 2);
  assign w_rsum_sum  = r_rsum + bus.mem_rdata;

  always_comb begin
    w_state_nxt     = r_state;
    w_index_nxt     = r_index;
    w_lane_nxt      = r_lane;
    w_word_nxt      = r_word;
    w_checksum_nxt  = r_checksum;
    w_rsum_nxt      = r_rsum;
    w_timer_nxt     = r_timer;
    w_mem_valid_nxt = r_mem_valid;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_wstrb_nxt = r_mem_wstrb;

    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          w_state_nxt    = S_COLLECT;
          w_index_nxt    = '0;
          w_lane_nxt     = 2'd0;
          w_word_nxt     = 24'd0;
          w_checksum_nxt = 32'd0;
          w_rsum_nxt     = 32'd0;
        end else begin
          w_state_nxt = r_state;
        end
      end

      S_COLLECT: begin
        if (w_byte_acc) begin
          w_lane_nxt = r_lane + 2'd1;
          case (r_lane)
            2'd0: w_word_nxt[7:0]   = i_byte_data;
            2'd1: w_word_nxt[15:8]  = i_byte_data;
            2'd2: w_word_nxt[23:16] = i_byte_data;
            default: begin
              w_state_nxt     = S_WRITE;
              w_checksum_nxt  = r_checksum + w_full_word;
              w_mem_wdata_nxt = w_full_word;
              w_mem_addr_nxt  = w_addr;
              w_mem_wstrb_nxt = 4'b1111;
              w_mem_valid_nxt = 1'b1;
              w_timer_nxt     = 16'd0;
            end
          endcase
        end else begin
          w_lane_nxt = r_lane;
        end
      end

      S_WRITE: begin
        if (w_fire) begin
          w_mem_valid_nxt = 1'b0;
          if (w_last) begin
            w_state_nxt = S_VERIFY;
            w_index_nxt = '0;
            w_rsum_nxt  = 32'd0;
          end else begin
            w_state_nxt = S_COLLECT;
            w_index_nxt = r_index + IW'(1);
          end
        end else if (w_timeout) begin
          w_mem_valid_nxt = 1'b0;
          w_state_nxt     = S_ERROR;
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
      end

      // mem_valid is low for one cycle after every completed read before the next address goes out.
      S_VERIFY: begin
        if (w_fire) begin
          w_mem_valid_nxt = 1'b0;
          w_rsum_nxt      = w_rsum_sum;
          w_index_nxt     = r_index + IW'(1);
          if (w_last) begin
            w_state_nxt = (w_rsum_sum == r_checksum) ? S_DONE : S_ERROR;
          end else begin
            w_state_nxt = S_VERIFY;
          end
        end else if (w_timeout) begin
          w_mem_valid_nxt = 1'b0;
          w_state_nxt     = S_ERROR;
        end else if (r_mem_valid) begin
          w_timer_nxt = r_timer + 16'd1;
        end else begin
          w_mem_valid_nxt = 1'b1;
          w_mem_addr_nxt  = w_addr;
          w_mem_wstrb_nxt = 4'b0000;
          w_timer_nxt     = 16'd0;
        end
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_mem_valid_nxt = 1'b0;
      end
    endcase
  end

  // Status outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_index      <= '0;
      r_lane       <= 2'd0;
      r_word       <= 24'd0;
      r_checksum   <= 32'd0;
      r_rsum       <= 32'd0;
      r_timer      <= 16'd0;
      r_mem_valid  <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_mem_wstrb  <= 4'b0000;
      r_byte_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_cpu_resetn <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_index      <= w_index_nxt;
      r_lane       <= w_lane_nxt;
      r_word       <= w_word_nxt;
      r_checksum   <= w_checksum_nxt;
      r_rsum       <= w_rsum_nxt;
      r_timer      <= w_timer_nxt;
      r_mem_valid  <= w_mem_valid_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_mem_wstrb  <= w_mem_wstrb_nxt;
      r_byte_ready <= (w_state_nxt == S_COLLECT);
      r_busy       <= (w_state_nxt == S_COLLECT) || (w_state_nxt == S_WRITE) ||
                      (w_state_nxt == S_VERIFY);
      r_done       <= (w_state_nxt == S_DONE);
      r_error      <= (w_state_nxt == S_ERROR);
      r_cpu_resetn <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_instr = 1'b0;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign o_byte_ready  = r_byte_ready;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;
  assign o_cpu_resetn  = r_cpu_resetn;
  assign o_checksum    = r_checksum;

endmodule
